// File: rtl/ihc_mailbox_apb.sv
// ihc_mailbox_apb: APB3 completer holding one inter-hart message FIFO.
// The sending hart pushes through TXDATA and the receiving hart pops through
// RXDATA. MSG_IRQ tells the receiver that a message is pending.
module ihc_mailbox_apb #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              MSG_IRQ
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DONE
  } rd_state_e;

  rd_state_e         state_q, state_d;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       rdata_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              irq_en_q, irq_en_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              irq_q;
  logic [31:0]       prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;

  logic [ADDR_W-3:0] word_addr;
  logic              sel_ctrl, sel_status, sel_tx, sel_rx, sel_clr;
  logic              setup, complete;
  logic              empty, full;
  logic              ram_rd_en, push, pop;
  logic [31:0]       status;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^PADDR[1:0];

  assign word_addr  = PADDR[ADDR_W-1:2];
  assign sel_ctrl   = (word_addr == (ADDR_W-2)'(0));
  assign sel_status = (word_addr == (ADDR_W-2)'(1));
  assign sel_tx     = (word_addr == (ADDR_W-2)'(2));
  assign sel_rx     = (word_addr == (ADDR_W-2)'(3));
  assign sel_clr    = (word_addr == (ADDR_W-2)'(4));

  assign setup    = PSEL & ~PENABLE;
  assign complete = PSEL & PENABLE & PREADY;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  assign status = {16'h0000, 8'(count_q), 4'h0, ovf_q, pend_q, full, empty};

  // RXDATA read sequencer: state register
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RXDATA read sequencer: next state, PREADY, RAM read strobe and pop
  always_comb begin
    state_d   = state_q;
    PREADY    = 1'b1;
    ram_rd_en = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (setup && !PWRITE && sel_rx && !empty) begin
          state_d   = ST_RD_WAIT;
          ram_rd_en = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        PREADY  = 1'b0;
        state_d = PSEL ? ST_RD_DONE : ST_IDLE;
      end
      ST_RD_DONE: begin
        state_d = ST_IDLE;
        pop     = PSEL & PENABLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data and error response, captured one cycle ahead so the outputs
  // come straight from flops and drop to their idle values on reset.
  always_comb begin
    prdata_d  = '0;
    pslverr_d = 1'b0;
    if (state_q == ST_RD_WAIT) begin
      if (PSEL) begin
        prdata_d = rdata_q;
      end
    end else if (setup) begin
      if (!PWRITE) begin
        if (sel_ctrl) begin
          prdata_d = {31'h0, irq_en_q};
        end else if (sel_status) begin
          prdata_d = status;
        end
        pslverr_d = sel_rx & empty;
      end else begin
        pslverr_d = sel_tx & full;
      end
    end
  end

  // Control/status/FIFO bookkeeping; side effects only on the completing edge
  always_comb begin
    irq_en_d = irq_en_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push     = 1'b0;
    if (complete && PWRITE) begin
      if (sel_ctrl) begin
        irq_en_d = PWDATA[0];
        if (PWDATA[1]) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          pend_d   = 1'b0;
        end
      end
      if (sel_clr) begin
        if (PWDATA[0]) pend_d = 1'b0;
        if (PWDATA[1]) ovf_d  = 1'b0;
      end
      // Set terms come after the clears so a same-edge set wins.
      if (sel_tx) begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          push     = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_q + CW'(1);
          pend_d   = 1'b1;
        end
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q - CW'(1);
    end
  end

  // Architectural registers and bus outputs
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      irq_en_q  <= 1'b0;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      irq_en_q  <= irq_en_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      irq_q     <= pend_q & irq_en_q;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  // FIFO storage: synchronous-read RAM, contents not reset
  always_ff @(posedge PCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= PWDATA;
    end
    if (ram_rd_en) begin
      rdata_q <= mem_q[rd_ptr_q];
    end
  end

  assign PRDATA  = prdata_q;
  assign PSLVERR = pslverr_q;
  assign MSG_IRQ = irq_q;

endmodule

// File: tb/tb_ihc_mailbox_apb.sv
// Bench for ihc_mailbox_apb: directed scenarios followed by random APB
// traffic, all checked against a queue-based mailbox model.
module tb_ihc_mailbox_apb;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        msg_irq;

  int vectors;
  int miscompares;

  // reference model state
  logic [31:0] mq[$];
  logic        m_irq_en;
  logic        m_pend;
  logic        m_ovf;

  ihc_mailbox_apb #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
    .PCLK    (clk),
    .PRESETN (rst_n),
    .PSEL    (psel),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PRDATA  (prdata),
    .PREADY  (pready),
    .PSLVERR (pslverr),
    .MSG_IRQ (msg_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [7:0] cnt;
    cnt = 8'(mq.size());
    return {16'h0000, cnt, 4'h0, m_ovf, m_pend, mq.size() == DEPTH, mq.size() == 0};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_irq_en = 1'b0;
    m_pend   = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // One complete APB transfer with a bounded wait for PREADY.
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int waits);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    while (!pready && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    rdata = prdata;
    err   = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Idle cycle after each transfer: MSG_IRQ has caught up, bus is quiet.
  task automatic idle_check();
    @(posedge clk); #1;
    check_eq("msg_irq", msg_irq, m_pend & m_irq_en);
    check_eq("idle_prdata", prdata, 32'h0);
    check_eq("idle_pready", pready, 1);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        err;
    int          w;
    logic        exp_err;
    exp_err = 1'b0;
    apb_xfer(1'b1, addr, data, rd, err, w);
    case (addr[7:2])
      6'd0: begin
        m_irq_en = data[0];
        if (data[1]) begin
          mq.delete();
          m_pend = 1'b0;
        end
      end
      6'd2: begin
        if (mq.size() == DEPTH) begin
          m_ovf   = 1'b1;
          exp_err = 1'b1;
        end else begin
          mq.push_back(data);
          m_pend = 1'b1;
        end
      end
      6'd4: begin
        if (data[0]) m_pend = 1'b0;
        if (data[1]) m_ovf  = 1'b0;
      end
      default: ;
    endcase
    check_eq("wr_pslverr", err, exp_err);
    check_eq("wr_waits", w, 0);
    idle_check();
  endtask

  task automatic do_read(input logic [7:0] addr);
    logic [31:0] rd;
    logic        err;
    int          w;
    logic [31:0] exp_d;
    logic        exp_err;
    int          exp_w;
    exp_d = 32'h0; exp_err = 1'b0; exp_w = 0;
    case (addr[7:2])
      6'd0: exp_d = {31'h0, m_irq_en};
      6'd1: exp_d = model_status();
      6'd3: begin
        if (mq.size() == 0) exp_err = 1'b1;
        else begin
          exp_d = mq.pop_front();
          exp_w = 1;
        end
      end
      default: ;
    endcase
    apb_xfer(1'b0, addr, 32'h0, rd, err, w);
    check_eq("rd_data", rd, exp_d);
    check_eq("rd_pslverr", err, exp_err);
    check_eq("rd_waits", w, exp_w);
    idle_check();
  endtask

  initial begin
    logic [5:0] off;
    int         r;
    vectors = 0; miscompares = 0;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    model_reset();
    rst_n = 1'b0;
    #13;
    check_eq("rst_pready", pready, 1);
    check_eq("rst_prdata", prdata, 32'h0);
    check_eq("rst_pslverr", pslverr, 0);
    check_eq("rst_irq", msg_irq, 0);
    @(negedge clk); rst_n = 1'b1;

    // reset STATUS, first message round trip
    do_read(8'h04);
    do_write(8'h00, 32'h1);
    do_write(8'h08, 32'hA5A5_0001);
    do_read(8'h04);
    do_read(8'h0C);
    do_read(8'h04);

    // fill, overflow, drain across the pointer wrap
    for (int i = 0; i < DEPTH; i++) do_write(8'h08, i);
    do_read(8'h04);
    do_write(8'h08, 32'hDEAD_BEEF);
    do_read(8'h04);
    for (int i = 0; i < DEPTH; i++) do_read(8'h0C);
    do_read(8'h0C);
    do_read(8'h04);

    // flush keeps OVF, CLR bit1 clears it
    for (int i = 0; i < 3; i++) do_write(8'h08, 32'h100 + i);
    do_write(8'h00, 32'h3);
    do_read(8'h04);
    do_read(8'h00);
    do_write(8'h10, 32'h2);
    do_read(8'h04);

    // PSEL dropped during the wait state: no pop
    do_write(8'h08, 32'h1234_5678);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h0C;
    @(posedge clk); #1;
    penable = 1'b1;
    check_eq("abort_wait", pready, 0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_idle", pready, 1);
    do_read(8'h04);
    do_read(8'h0C);

    // asynchronous reset in the middle of a wait state
    do_write(8'h08, 32'h0BAD_F00D);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h0C;
    @(posedge clk); #1;
    penable = 1'b1;
    check_eq("rstwait_pready", pready, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstmid_pready", pready, 1);
    check_eq("rstmid_prdata", prdata, 32'h0);
    check_eq("rstmid_pslverr", pslverr, 0);
    check_eq("rstmid_irq", msg_irq, 0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    model_reset();
    do_read(8'h04);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 35)      do_write({6'd2, 2'($urandom_range(0, 3))}, $urandom);
      else if (r < 65) do_read({6'd3, 2'($urandom_range(0, 3))});
      else if (r < 78) do_read({6'd1, 2'($urandom_range(0, 3))});
      else if (r < 84) begin
        if ($urandom_range(0, 7) == 0) do_write(8'h00, $urandom);
        else do_write(8'h00, $urandom & 32'hFFFF_FFFD);
      end
      else if (r < 90) do_write({6'd4, 2'($urandom_range(0, 3))}, $urandom);
      else if (r < 94) do_read(8'h00);
      else begin
        off = 6'($urandom_range(5, 63));
        if ($urandom_range(0, 1) == 1) do_write({off, 2'b00}, $urandom);
        else do_read({off, 2'b00});
      end
    end
    do_read(8'h04);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
